// File: rtl/counter_pkg.sv
// Purpose: constants shared by the counter block (default width, direction encoding).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package counter_pkg;

  // Default bit width of data, reset_variable and count.
  localparam int DEFAULT_WIDTH = 8;

  // Direction encoding of the up_down input.
  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Purpose: combinational next-state logic for the modulo up/down counter with parallel load.
// Latency: purely combinational, zero cycles.
// Backpressure: none; a next value is produced for every input combination.
//
// Ports:
//   count          current registered value
//   up_down        direction, UP = count up, DOWN = count down
//   load           parallel-load strobe, overrides counting
//   data           value taken when load is set (no range check)
//   reset_variable terminal value; counting range is 0..reset_variable
//   next_count     value to be registered on the next rising edge
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] reset_variable,
  output logic [WIDTH-1:0] next_count
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = '0;

  always_comb begin
    next_count = count;
    if (load) begin
      next_count = data;
    end else if (up_down == UP) begin
      // ">=" rather than "==" so an out-of-range loaded value falls back to 0.
      if (count >= reset_variable) next_count = ZERO;
      else                         next_count = count + ONE;
    end else begin
      // Out-of-range values re-enter the range from the top when counting down.
      if ((count == ZERO) || (count > reset_variable)) next_count = reset_variable;
      else                                             next_count = count - ONE;
    end
  end

endmodule : counter_next

// File: rtl/counter.sv
// Purpose: WIDTH-bit up/down counter wrapping over 0..reset_variable, with synchronous load.
// Latency: load and step results are visible one cycle after the sampling edge.
// Backpressure: none; the counter advances on every edge while out of reset.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous reset, active-low; clears count immediately
//   up_down        direction, 1 = up, 0 = down
//   load           synchronous parallel-load strobe, active-high
//   data           value loaded into count
//   reset_variable terminal/modulus value
//   count          registered counter value
module counter
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] reset_variable,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] next_count;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_counter_next (
    .count         (count),
    .up_down       (up_down),
    .load          (load),
    .data          (data),
    .reset_variable(reset_variable),
    .next_count    (next_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count <= '0;
    else      count <= next_count;
  end

endmodule : counter

// File: tb/tb_counter.sv
// Purpose: self-checking bench for counter: directed scenarios plus randomized traffic.
// Latency: n/a.
// Backpressure: n/a.
module tb_counter;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         up_down;
  logic         load;
  logic [W-1:0] data;
  logic [W-1:0] reset_variable;
  logic [W-1:0] count;

  int compared   = 0;
  int mismatched = 0;
  int exp_cnt    = 0;

  counter #(
    .WIDTH(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .up_down       (up_down),
    .load          (load),
    .data          (data),
    .reset_variable(reset_variable),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the legal range is a ring of rv+1 values; out-of-range values
  // re-enter at 0 going up and at rv going down.
  function automatic int model_next(int c, int rv, bit ld, int d, bit up);
    int m;
    if (ld) return d;
    m = rv + 1;
    if (c > rv) return up ? 0 : rv;
    return up ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  task automatic check(input string tag, input int expected);
    logic [W-1:0] e;
    e = W'(expected);
    compared++;
    assert (count === e) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, count, e);
    end
  endtask

  // One rising edge: advance the model with the inputs sampled at that edge,
  // then compare shortly after the edge.
  task automatic tick(input string tag);
    @(posedge clk);
    if (!rst) exp_cnt = 0;
    else      exp_cnt = model_next(exp_cnt, int'(reset_variable), load, int'(data), up_down);
    #1;
    check(tag, exp_cnt);
  endtask

  initial begin
    rst            = 1'b0;
    up_down        = 1'b1;
    load           = 1'b0;
    data           = '0;
    reset_variable = W'(99);

    // Reset held for 100 ns with the clock running; load during reset is ignored.
    #1;
    check("reset_initial", 0);
    for (int i = 0; i < 10; i++) begin
      load = (i % 3 == 0);
      data = W'(55);
      tick("reset_hold");
    end
    load = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick("after_reset_1"); check("after_reset_1_const", 1);
    tick("after_reset_2"); check("after_reset_2_const", 2);
    tick("after_reset_3"); check("after_reset_3_const", 3);
    for (int i = 0; i < 5; i++) tick("count_up");

    // Load 80 then count up across the wrap at 99.
    load = 1'b1; data = W'(80);
    tick("load_80"); check("load_80_const", 80);
    load = 1'b0;
    for (int i = 0; i < 21; i++) tick("up_wrap");
    check("up_wrap_end_const", 1);

    // Count down from 2 across zero.
    load = 1'b1; data = W'(2);
    tick("load_2");
    load = 1'b0; up_down = 1'b0;
    tick("down_1");  check("down_1_const", 1);
    tick("down_0");  check("down_0_const", 0);
    tick("down_99"); check("down_99_const", 99);
    tick("down_98"); check("down_98_const", 98);

    // Out-of-range load, then step in each direction.
    load = 1'b1; data = W'(120); up_down = 1'b1;
    tick("load_120_up"); check("load_120_up_const", 120);
    load = 1'b0;
    tick("oor_up"); check("oor_up_const", 0);
    load = 1'b1; data = W'(120); up_down = 1'b0;
    tick("load_120_dn"); check("load_120_dn_const", 120);
    load = 1'b0;
    tick("oor_dn"); check("oor_dn_const", 99);

    // Asynchronous reset pulse between edges while counting from 50.
    load = 1'b1; data = W'(50); up_down = 1'b1;
    tick("load_50");
    load = 1'b0;
    tick("from_50"); check("from_50_const", 51);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_reset_now", 0);
    #2;
    rst = 1'b1;
    exp_cnt = 0;
    tick("restart"); check("restart_const", 1);

    // reset_variable = 0 pins the count at 0 in both directions.
    reset_variable = '0;
    for (int i = 0; i < 4; i++) begin
      up_down = i[0];
      tick("rv0_hold");
      check("rv0_hold_const", 0);
    end

    // Full-range modulus gives plain binary wrap.
    reset_variable = W'(255);
    load = 1'b1; data = W'(254);
    tick("load_254");
    load = 1'b0; up_down = 1'b1;
    tick("full_255"); check("full_255_const", 255);
    tick("full_0");   check("full_0_const", 0);
    up_down = 1'b0;
    tick("full_dn_255"); check("full_dn_255_const", 255);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      load    = ($urandom_range(0, 9) == 0);
      data    = W'($urandom);
      up_down = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       reset_variable = '0;
          1:       reset_variable = W'(255);
          2:       reset_variable = W'($urandom_range(1, 5));
          default: reset_variable = W'($urandom);
        endcase
      end
      if ($urandom_range(0, 39) == 0) begin
        #2;
        rst = 1'b0;
        #1;
        exp_cnt = 0;
        check("rand_async_reset", 0);
        #1;
        rst = 1'b1;
      end
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_counter
